// File: rtl/lsu_mem_adapter.sv
// -----------------------------------------------------------------------------
// lsu_mem_adapter
//
// Load/store adapter placed directly in front of a synchronous single-port
// data memory (64-bit words, per-byte write enables, 1-cycle registered read,
// write-first). It takes byte-addressed loads/stores of 1/2/4/8 bytes, drives
// the memory pins, and aligns and extends load data. An access that crosses a
// 64-bit word boundary is split into a lower and an upper memory cycle.
//
// Build option:
//   CH0RE_LSU_MISALIGN_EN  defined   -> word-crossing accesses are split and
//                                       performed; o_rsp_err is always 0.
//                          undefined -> word-crossing accesses are accepted,
//                                       touch no memory, and answer in cycle 1
//                                       with o_rsp_err=1 and o_rsp_rdata=0.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   i_req_valid/o_req_ready   request handshake (ready only in IDLE)
//   i_req_we            1=store, 0=load
//   i_req_size          0=byte 1=half 2=word 3=double
//   i_req_unsigned      loads zero-extend when 1, sign-extend when 0
//   i_req_addr          byte address {word index, 3-bit offset}
//   i_req_wdata         store data, right-justified
//   o_rsp_valid/i_rsp_ready   response handshake
//   o_rsp_rdata         load result (0 for stores)
//   o_rsp_err           misaligned access rejected
//   o_mem_addr/o_mem_wdata/o_mem_wen  memory request pins
//   i_mem_rdata         memory read data (valid the cycle after the address)
//
// Handshakes: a transfer happens on a clk edge where valid and ready are both
// 1. A response, once valid, holds o_rsp_rdata/o_rsp_err stable until it is
// taken; request fields are captured only on the accepting edge.
//
// Internal state is held in state_q (state_e) for observation.
// -----------------------------------------------------------------------------
module lsu_mem_adapter #(
  parameter int DEPTH      = 2048,
  parameter int ADDR_WIDTH = $clog2(DEPTH),
  parameter int DATA_WIDTH = 64,
  parameter int DATA_BYTES = DATA_WIDTH / 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    i_req_valid,
  output logic                    o_req_ready,
  input  logic                    i_req_we,
  input  logic [1:0]              i_req_size,
  input  logic                    i_req_unsigned,
  input  logic [ADDR_WIDTH+2:0]   i_req_addr,
  input  logic [DATA_WIDTH-1:0]   i_req_wdata,
  output logic                    o_rsp_valid,
  input  logic                    i_rsp_ready,
  output logic [DATA_WIDTH-1:0]   o_rsp_rdata,
  output logic                    o_rsp_err,
  output logic [ADDR_WIDTH-1:0]   o_mem_addr,
  output logic [DATA_WIDTH-1:0]   o_mem_wdata,
  output logic [DATA_BYTES-1:0]   o_mem_wen,
  input  logic [DATA_WIDTH-1:0]   i_mem_rdata
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ST_HI = 3'd1,
    RD_LO = 3'd2,
    RD_HI = 3'd3,
    RSP   = 3'd4
  } state_e;

`ifdef CH0RE_LSU_MISALIGN_EN
  localparam bit MisalignEn = 1'b1;
`else
  localparam bit MisalignEn = 1'b0;
`endif

  state_e state_q, state_d;

  // ---------------------------------------------------------------------------
  // Request decode (combinational, valid while in IDLE)
  // ---------------------------------------------------------------------------
  logic [2:0]            req_off;
  logic [ADDR_WIDTH-1:0] req_idx;
  logic [3:0]            req_nbytes;
  logic                  req_split;
  logic [7:0]            req_lanes;   // right-justified byte mask
  logic [7:0]            req_m_lo;    // lower-word byte enables
  logic [63:0]           req_s_lo;    // lower-word store data
  logic                  accept;

  assign req_off    = i_req_addr[2:0];
  assign req_idx    = i_req_addr[ADDR_WIDTH+2:3];
  assign req_nbytes = 4'd1 << i_req_size;
  assign req_split  = ({1'b0, req_off} + req_nbytes) > 4'd8;
  assign req_lanes  = 8'hFF >> (4'd8 - req_nbytes);
  assign req_m_lo   = req_lanes << req_off;
  assign req_s_lo   = i_req_wdata << {req_off, 3'b000};
  assign accept     = i_req_valid && (state_q == IDLE);

`ifdef CH0RE_LSU_MISALIGN_EN
  // Upper half of a word-crossing access: the bytes shifted out of the lower
  // word, aimed at the next word index (wrapping at the top of memory).
  logic [ADDR_WIDTH-1:0] req_idx_hi;
  logic [63:0]           req_s_hi;
  logic [7:0]            req_m_hi;

  assign req_idx_hi = (req_idx == ADDR_WIDTH'(DEPTH - 1)) ? '0
                                                          : req_idx + ADDR_WIDTH'(1);
  // Shift of 64 (offset 0) yields 0, matching an empty upper half.
  assign req_s_hi   = i_req_wdata >> (7'd64 - {1'b0, req_off, 3'b000});
  assign req_m_hi   = 8'(({8'b0, req_lanes} << req_off) >> 8);

  logic                  split_q;
  logic [ADDR_WIDTH-1:0] idx_hi_q;
  logic [63:0]           s_hi_q;
  logic [7:0]            m_hi_q;
  logic [63:0]           lo_q;
`endif

  logic [2:0]  off_q;
  logic [1:0]  size_q;
  logic        uns_q;
  logic [63:0] rdata_q, rdata_d;
  logic        err_q, err_d;

  // Align {hi,lo} down by the byte offset, keep the access width, extend.
  function automatic logic [63:0] load_result(input logic [127:0] hl,
                                              input logic [2:0]   off,
                                              input logic [1:0]   size,
                                              input logic         uns);
    logic [63:0] r;
    logic [63:0] res;
    r = 64'(hl >> {off, 3'b000});
    case (size)
      2'd0:    res = {{56{~uns & r[7]}},  r[7:0]};
      2'd1:    res = {{48{~uns & r[15]}}, r[15:0]};
      2'd2:    res = {{32{~uns & r[31]}}, r[31:0]};
      default: res = r;
    endcase
    return res;
  endfunction

  // ---------------------------------------------------------------------------
  // State and captured request fields
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      rdata_q  <= '0;
      err_q    <= 1'b0;
      off_q    <= '0;
      size_q   <= '0;
      uns_q    <= 1'b0;
`ifdef CH0RE_LSU_MISALIGN_EN
      split_q  <= 1'b0;
      idx_hi_q <= '0;
      s_hi_q   <= '0;
      m_hi_q   <= '0;
      lo_q     <= '0;
`endif
    end else begin
      state_q <= state_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
      if (accept) begin
        off_q    <= req_off;
        size_q   <= i_req_size;
        uns_q    <= i_req_unsigned;
`ifdef CH0RE_LSU_MISALIGN_EN
        split_q  <= req_split;
        idx_hi_q <= req_idx_hi;
        s_hi_q   <= req_s_hi;
        m_hi_q   <= req_m_hi;
`endif
      end
`ifdef CH0RE_LSU_MISALIGN_EN
      if (state_q == RD_LO) lo_q <= i_mem_rdata;
`endif
    end
  end

  // ---------------------------------------------------------------------------
  // Next state and outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d     = state_q;
    rdata_d     = rdata_q;
    err_d       = err_q;
    o_req_ready = 1'b0;
    o_rsp_valid = 1'b0;
    o_mem_addr  = req_idx;
    o_mem_wdata = req_s_lo;
    o_mem_wen   = '0;

    case (state_q)
      IDLE: begin
        o_req_ready = 1'b1;
        if (i_req_valid) begin
          if (req_split && !MisalignEn) begin
            // Rejected crossing access: no memory traffic, error response.
            rdata_d = '0;
            err_d   = 1'b1;
            state_d = RSP;
          end else if (i_req_we) begin
            // The memory samples the lower half on the accepting edge.
            // Gated by rst_n so nothing is written while reset is held.
            o_mem_wen = rst_n ? req_m_lo : '0;
            rdata_d   = '0;
            err_d     = 1'b0;
            state_d   = req_split ? ST_HI : RSP;
          end else begin
            err_d   = 1'b0;
            state_d = RD_LO;
          end
        end
      end

`ifdef CH0RE_LSU_MISALIGN_EN
      ST_HI: begin
        o_mem_addr  = idx_hi_q;
        o_mem_wdata = s_hi_q;
        o_mem_wen   = m_hi_q;
        state_d     = RSP;
      end
`endif

      RD_LO: begin
`ifdef CH0RE_LSU_MISALIGN_EN
        if (split_q) begin
          // Lower word is on i_mem_rdata now; fetch the upper word next.
          o_mem_addr = idx_hi_q;
          state_d    = RD_HI;
        end else begin
          rdata_d = load_result({64'b0, i_mem_rdata}, off_q, size_q, uns_q);
          state_d = RSP;
        end
`else
        rdata_d = load_result({64'b0, i_mem_rdata}, off_q, size_q, uns_q);
        state_d = RSP;
`endif
      end

`ifdef CH0RE_LSU_MISALIGN_EN
      RD_HI: begin
        rdata_d = load_result({i_mem_rdata, lo_q}, off_q, size_q, uns_q);
        state_d = RSP;
      end
`endif

      RSP: begin
        o_rsp_valid = 1'b1;
        if (i_rsp_ready) state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  assign o_rsp_rdata = rdata_q;
  assign o_rsp_err   = err_q;

endmodule

// File: tb/tb_lsu_mem_adapter.sv
`timescale 1ns/1ps
module tb_lsu_mem_adapter;

  localparam int DEPTH = 2048;
  localparam int AW    = 11;

  // ---------------------------------------------------------------------------
  // Clock / reset / DUT
  // ---------------------------------------------------------------------------
  logic          clk = 1'b0;
  logic          rst_n;
  logic          i_req_valid;
  logic          o_req_ready;
  logic          i_req_we;
  logic [1:0]    i_req_size;
  logic          i_req_unsigned;
  logic [AW+2:0] i_req_addr;
  logic [63:0]   i_req_wdata;
  logic          o_rsp_valid;
  logic          i_rsp_ready;
  logic [63:0]   o_rsp_rdata;
  logic          o_rsp_err;
  logic [AW-1:0] o_mem_addr;
  logic [63:0]   o_mem_wdata;
  logic [7:0]    o_mem_wen;
  logic [63:0]   i_mem_rdata = '0;

  always #5 clk = ~clk;

  lsu_mem_adapter #(.DEPTH(DEPTH)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .i_req_valid   (i_req_valid),
    .o_req_ready   (o_req_ready),
    .i_req_we      (i_req_we),
    .i_req_size    (i_req_size),
    .i_req_unsigned(i_req_unsigned),
    .i_req_addr    (i_req_addr),
    .i_req_wdata   (i_req_wdata),
    .o_rsp_valid   (o_rsp_valid),
    .i_rsp_ready   (i_rsp_ready),
    .o_rsp_rdata   (o_rsp_rdata),
    .o_rsp_err     (o_rsp_err),
    .o_mem_addr    (o_mem_addr),
    .o_mem_wdata   (o_mem_wdata),
    .o_mem_wen     (o_mem_wen),
    .i_mem_rdata   (i_mem_rdata)
  );

  // Memory: 64-bit words, byte enables, registered read, write-first.
  logic [63:0] mem [0:DEPTH-1] = '{default: '0};
  int wen_cycles = 0;

  always @(posedge clk) begin
    logic [63:0] w;
    w = mem[o_mem_addr];
    for (int b = 0; b < 8; b++)
      if (o_mem_wen[b]) w[8*b +: 8] = o_mem_wdata[8*b +: 8];
    mem[o_mem_addr] <= w;
    i_mem_rdata     <= w;
    if (o_mem_wen != 8'h00) wen_cycles <= wen_cycles + 1;
  end

  int n_checks = 0;
  int n_pass   = 0;

  // ---------------------------------------------------------------------------
  // Driver: one request, then its response. hold>0 keeps i_rsp_ready low for
  // that many cycles after the response appears.
  // ---------------------------------------------------------------------------
  task automatic do_req(input string name, input logic we, input logic [1:0] size,
                        input logic uns, input logic [AW+2:0] addr,
                        input logic [63:0] wdata, input logic [7:0] exp_wen,
                        input int exp_lat, input logic [63:0] exp_rdata,
                        input logic exp_err, input int hold);
    int lat;
    int wen_before;
    @(negedge clk);
    i_req_valid    = 1'b1;
    i_req_we       = we;
    i_req_size     = size;
    i_req_unsigned = uns;
    i_req_addr     = addr;
    i_req_wdata    = we ? wdata : {$urandom, $urandom};
    i_rsp_ready    = (hold == 0);
    #1;
    n_checks++; if (o_req_ready !== 1'b1) $display("FAIL %s req_ready: got %b want 1", name, o_req_ready); else n_pass++;
    n_checks++; if (o_mem_wen !== exp_wen) $display("FAIL %s idle_wen: got %h want %h", name, o_mem_wen, exp_wen); else n_pass++;
    @(posedge clk);
    #1;
    i_req_valid = 1'b0;
    i_req_we    = 1'b0;
    i_req_addr  = AW'($urandom_range(0, DEPTH - 1)) << 3;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (o_rsp_valid !== 1'b1 && lat < 12);
    n_checks++; if (lat != exp_lat) $display("FAIL %s latency: got %0d want %0d", name, lat, exp_lat); else n_pass++;
    n_checks++; if (o_rsp_rdata !== exp_rdata) $display("FAIL %s rdata: got %h want %h", name, o_rsp_rdata, exp_rdata); else n_pass++;
    n_checks++; if (o_rsp_err !== exp_err) $display("FAIL %s err: got %b want %b", name, o_rsp_err, exp_err); else n_pass++;
    if (hold > 0) begin
      wen_before = wen_cycles;
      for (int c = 0; c < hold; c++) begin
        @(negedge clk);
        n_checks++;
        if (o_rsp_valid !== 1'b1 || o_rsp_rdata !== exp_rdata || o_rsp_err !== exp_err || o_req_ready !== 1'b0)
          $display("FAIL %s hold%0d: got valid=%b rdata=%h err=%b ready=%b want 1/%h/%b/0",
                   name, c, o_rsp_valid, o_rsp_rdata, o_rsp_err, o_req_ready, exp_rdata, exp_err);
        else n_pass++;
      end
      n_checks++; if (wen_cycles != wen_before) $display("FAIL %s hold_writes: got %0d want 0", name, wen_cycles - wen_before); else n_pass++;
      i_rsp_ready = 1'b1;
    end
    @(posedge clk);
    #1;
    n_checks++;
    if (o_rsp_valid !== 1'b0 || o_req_ready !== 1'b1)
      $display("FAIL %s release: got valid=%b ready=%b want 0/1", name, o_rsp_valid, o_req_ready);
    else n_pass++;
  endtask

  // ---------------------------------------------------------------------------
  // Scenarios
  // ---------------------------------------------------------------------------
  task automatic test_reset();
    rst_n = 1'b0;
    #12;
    n_checks++; if (o_req_ready !== 1'b1)  $display("FAIL reset req_ready: got %b want 1", o_req_ready); else n_pass++;
    n_checks++; if (o_rsp_valid !== 1'b0)  $display("FAIL reset rsp_valid: got %b want 0", o_rsp_valid); else n_pass++;
    n_checks++; if (o_rsp_rdata !== 64'h0) $display("FAIL reset rsp_rdata: got %h want 0", o_rsp_rdata); else n_pass++;
    n_checks++; if (o_rsp_err !== 1'b0)    $display("FAIL reset rsp_err: got %b want 0", o_rsp_err); else n_pass++;
    n_checks++; if (o_mem_wen !== 8'h00)   $display("FAIL reset mem_wen: got %h want 0", o_mem_wen); else n_pass++;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_double();
    do_req("st_d", 1'b1, 2'd3, 1'b0, 14'h10, 64'h1122334455667788, 8'hFF, 1, 64'h0, 1'b0, 0);
    n_checks++; if (mem[2] !== 64'h1122334455667788) $display("FAIL st_d mem2: got %h want 1122334455667788", mem[2]); else n_pass++;
    do_req("ld_d", 1'b0, 2'd3, 1'b0, 14'h10, 64'h0, 8'h00, 2, 64'h1122334455667788, 1'b0, 0);
  endtask

  task automatic test_byte();
    do_req("st_b", 1'b1, 2'd0, 1'b0, 14'h13, 64'h80, 8'h08, 1, 64'h0, 1'b0, 0);
    n_checks++; if (mem[2] !== 64'h1122334480667788) $display("FAIL st_b mem2: got %h want 1122334480667788", mem[2]); else n_pass++;
    do_req("ld_b_s", 1'b0, 2'd0, 1'b0, 14'h13, 64'h0, 8'h00, 2, 64'hFFFFFFFFFFFFFF80, 1'b0, 0);
    do_req("ld_b_u", 1'b0, 2'd0, 1'b1, 14'h13, 64'h0, 8'h00, 2, 64'h0000000000000080, 1'b0, 0);
    do_req("ld_h_s", 1'b0, 2'd1, 1'b0, 14'h12, 64'h0, 8'h00, 2, 64'hFFFFFFFFFFFF8066, 1'b0, 0);
  endtask

  task automatic test_split();
`ifdef CH0RE_LSU_MISALIGN_EN
    do_req("st_w_x", 1'b1, 2'd2, 1'b0, 14'h1E, 64'hDEADBEEF, 8'hC0, 2, 64'h0, 1'b0, 0);
    n_checks++; if (mem[3] !== 64'hBEEF000000000000) $display("FAIL st_w_x mem3: got %h want beef000000000000", mem[3]); else n_pass++;
    n_checks++; if (mem[4] !== 64'h000000000000DEAD) $display("FAIL st_w_x mem4: got %h want 000000000000dead", mem[4]); else n_pass++;
    do_req("ld_w_x_u", 1'b0, 2'd2, 1'b1, 14'h1E, 64'h0, 8'h00, 3, 64'h00000000DEADBEEF, 1'b0, 0);
    do_req("ld_w_x_s", 1'b0, 2'd2, 1'b0, 14'h1E, 64'h0, 8'h00, 3, 64'hFFFFFFFFDEADBEEF, 1'b0, 0);
`else
    do_req("st_w_x", 1'b1, 2'd2, 1'b0, 14'h1E, 64'hDEADBEEF, 8'h00, 1, 64'h0, 1'b1, 0);
    n_checks++; if (mem[3] !== 64'h0) $display("FAIL st_w_x mem3: got %h want 0", mem[3]); else n_pass++;
    n_checks++; if (mem[4] !== 64'h0) $display("FAIL st_w_x mem4: got %h want 0", mem[4]); else n_pass++;
    do_req("ld_w_x_u", 1'b0, 2'd2, 1'b1, 14'h1E, 64'h0, 8'h00, 1, 64'h0, 1'b1, 0);
`endif
  endtask

  task automatic test_wrap();
`ifdef CH0RE_LSU_MISALIGN_EN
    do_req("st_h_wrap", 1'b1, 2'd1, 1'b0, 14'h3FFF, 64'hA55A, 8'h80, 2, 64'h0, 1'b0, 0);
    n_checks++; if (mem[DEPTH-1] !== 64'h5A00000000000000) $display("FAIL st_h_wrap memtop: got %h want 5a00000000000000", mem[DEPTH-1]); else n_pass++;
    n_checks++; if (mem[0] !== 64'h00000000000000A5) $display("FAIL st_h_wrap mem0: got %h want a5", mem[0]); else n_pass++;
    do_req("ld_h_wrap", 1'b0, 2'd1, 1'b1, 14'h3FFF, 64'h0, 8'h00, 3, 64'h000000000000A55A, 1'b0, 0);
`else
    do_req("st_h_wrap", 1'b1, 2'd1, 1'b0, 14'h3FFF, 64'hA55A, 8'h00, 1, 64'h0, 1'b1, 0);
    n_checks++; if (mem[DEPTH-1] !== 64'h0) $display("FAIL st_h_wrap memtop: got %h want 0", mem[DEPTH-1]); else n_pass++;
    n_checks++; if (mem[0] !== 64'h0) $display("FAIL st_h_wrap mem0: got %h want 0", mem[0]); else n_pass++;
`endif
  endtask

  task automatic test_back_to_back();
    // Store then immediate load of the same word sees the new bytes.
    do_req("st_w_top", 1'b1, 2'd2, 1'b0, 14'h0C, 64'hCAFEF00D, 8'hF0, 1, 64'h0, 1'b0, 0);
    do_req("ld_d_top", 1'b0, 2'd3, 1'b0, 14'h08, 64'h0, 8'h00, 2, 64'hCAFEF00D00000000, 1'b0, 0);
  endtask

  task automatic test_hold();
    do_req("ld_hold", 1'b0, 2'd3, 1'b0, 14'h10, 64'h0, 8'h00, 2, 64'h1122334480667788, 1'b0, 5);
  endtask

  task automatic test_reset_mid();
    int bad;
    @(negedge clk);
    i_req_valid    = 1'b1;
    i_req_we       = 1'b0;
    i_req_unsigned = 1'b1;
`ifdef CH0RE_LSU_MISALIGN_EN
    i_req_size     = 2'd2;
    i_req_addr     = 14'h1E;
`else
    i_req_size     = 2'd3;
    i_req_addr     = 14'h10;
`endif
    @(posedge clk);
    #1;
    i_req_valid = 1'b0;
`ifdef CH0RE_LSU_MISALIGN_EN
    @(posedge clk);   // now in the upper-word read cycle
`endif
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    n_checks++; if (o_rsp_valid !== 1'b0) $display("FAIL rst_mid rsp_valid: got %b want 0", o_rsp_valid); else n_pass++;
    n_checks++; if (o_mem_wen !== 8'h00)  $display("FAIL rst_mid mem_wen: got %h want 0", o_mem_wen); else n_pass++;
    @(negedge clk);
    rst_n = 1'b1;
    bad = 0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      if (o_rsp_valid !== 1'b0 || o_req_ready !== 1'b1) bad++;
    end
    n_checks++; if (bad != 0) $display("FAIL rst_mid idle_after: got %0d bad cycles want 0", bad); else n_pass++;
    do_req("ld_after_rst", 1'b0, 2'd3, 1'b0, 14'h10, 64'h0, 8'h00, 2, 64'h1122334480667788, 1'b0, 0);
  endtask

  // ---------------------------------------------------------------------------
  // Sequence and report
  // ---------------------------------------------------------------------------
  initial begin
    i_req_valid    = 1'b0;
    i_req_we       = 1'b0;
    i_req_size     = 2'd0;
    i_req_unsigned = 1'b0;
    i_req_addr     = '0;
    i_req_wdata    = '0;
    i_rsp_ready    = 1'b1;
    test_reset();
    test_double();
    test_byte();
    test_split();
    test_wrap();
    test_back_to_back();
    test_hold();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/lsu_mem_adapter.md
Name: lsu_mem_adapter

Overview:
- Load/store adapter that sits directly upstream of the synchronous single-port data memory (64-bit words, per-byte write enables, 1-cycle registered read, write-first).
- Accepts byte-addressed load/store requests of size 1/2/4/8 bytes over a valid/ready handshake.
- Drives the memory's address, write-data and byte-enable pins; aligns and extends returned load data.
- Splits accesses that cross a 64-bit word into two memory cycles.

Parameters:
- DEPTH, 2048, memory depth in 64-bit words.
- ADDR_WIDTH, $clog2(DEPTH), memory word-index width.
- DATA_WIDTH, 64, word width; only 64 is supported.
- DATA_BYTES, DATA_WIDTH/8, byte lanes per word.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- i_req_valid  in  1  request valid.
- o_req_ready  out  1  request ready.
- i_req_we  in  1  1=store, 0=load.
- i_req_size  in  2  0=byte, 1=half, 2=word, 3=double.
- i_req_unsigned  in  1  load zero-extends when 1, sign-extends when 0.
- i_req_addr  in  ADDR_WIDTH+3  byte address: [ADDR_WIDTH+2:3] is the word index, [2:0] is the offset.
- i_req_wdata  in  64  store data, right-justified.
- o_rsp_valid  out  1  response valid.
- i_rsp_ready  in  1  response accept.
- o_rsp_rdata  out  64  load result; 0 for stores.
- o_rsp_err  out  1  misaligned access rejected (see Optional Feature).
- o_mem_addr  out  ADDR_WIDTH  to memory i_addr.
- o_mem_wdata  out  64  to memory i_wdata.
- o_mem_wen  out  8  to memory i_wen.
- i_mem_rdata  in  64  from memory o_rdata.

Behaviour:
- Clock/reset: one clock, clk. Reset rst_n is asynchronous, active-low.
- Reset values: state=IDLE, o_req_ready=1, o_rsp_valid=0, o_rsp_rdata=0, o_rsp_err=0, o_mem_wen=0.
- Request acceptance:
  - A request is accepted on a clk edge where i_req_valid and o_req_ready are both 1.
  - o_req_ready=1 only in IDLE.
  - One transaction is in flight at a time.
- Request fields: nbytes = 1<<size. off = addr[2:0]. idx = addr word index. split = (off + nbytes > 8).
- Upper word index = (idx+1) mod DEPTH; word DEPTH-1 wraps to word 0.
- Memory pins in IDLE:
  - o_mem_addr = idx, combinational from the request.
  - o_mem_wen = lower lanes when i_req_valid && i_req_we, otherwise 0.
  - The memory therefore samples the first access on the acceptance edge.
- Store lanes:
  - S = {64'b0, wdata} << (8*off), 128 bits.
  - Byte mask M = ((1<<nbytes)-1) << off, 16 bits.
  - Lower access uses S[63:0] with M[7:0]; upper access uses S[127:64] with M[15:8].
- States:
  - IDLE: on an accepted request, go to ST_HI (split store), RSP (non-split store), RD_LO (load).
  - ST_HI: drive the upper index, S[127:64] and M[15:8] for one cycle, then go to RSP.
  - RD_LO: i_mem_rdata holds the lower word; capture it into a lo register. If split, drive the upper index and go to RD_HI. Otherwise form the result and go to RSP.
  - RD_HI: i_mem_rdata holds the upper word; form the result and go to RSP.
  - RSP: o_rsp_valid=1, with o_rsp_rdata/o_rsp_err stable. On i_rsp_ready, go to IDLE.
- o_mem_wen=0 in every state except IDLE and ST_HI.
- Load result:
  - R = {hi,lo} >> (8*off); hi=0 when the access is not split.
  - Take the low nbytes bytes of R.
  - Zero- or sign-extend from bit 8*nbytes-1; size=3 passes through.
- Latency, counted from the acceptance cycle (cycle 0):
  - Store non-split: o_rsp_valid in cycle 1.
  - Store split: o_rsp_valid in cycle 2.
  - Load non-split: o_rsp_valid in cycle 2.
  - Load split: o_rsp_valid in cycle 3.
- Next request: it can be accepted in the cycle after the response handshake. A load issued after a store to the same word returns the new data.
- i_rsp_ready held low keeps RSP indefinitely with outputs stable.
- i_req_ready is not a port; i_req_valid changes outside IDLE are ignored.
- Reset mid-operation: immediate return to IDLE, o_mem_wen=0, no response. A split store interrupted in ST_HI leaves its lower half written.

Optional Feature:
- Macro: CH0RE_LSU_MISALIGN_EN.
- Defined: split accesses are performed as above; o_rsp_err is always 0.
- Undefined:
  - A split request is accepted but performs no memory write; o_mem_wen=0 in IDLE for it.
  - ST_HI and RD_HI are not built.
  - Response in cycle 1 with o_rsp_err=1 and o_rsp_rdata=0.
  - Non-split behaviour is unchanged.

Test Plan:
- Store double 0x1122334455667788 @0x10, then load double @0x10 → memory word 2 = 0x1122334455667788; load response in cycle 2 with rdata 0x1122334455667788, err 0.
- Store byte 0x80 @0x13, then load byte signed @0x13 → wen=0x08 only; rdata 0xFFFFFFFFFFFFFF80. Unsigned load returns 0x80.
- Store word 0xDEADBEEF @0x1E (split) → word 3 lanes 6-7 = 0xBEEF, word 4 lanes 0-1 = 0xDEAD; response cycle 2. Load word unsigned @0x1E → 0x00000000DEADBEEF in cycle 3. With the macro off: err=1, no write.
- Store half @ byte address 8*DEPTH-1 → lane 7 of word DEPTH-1 and lane 0 of word 0 written (wrap).
- Load accepted, i_rsp_ready held low 5 cycles → o_rsp_valid and rdata stable, o_req_ready=0, no memory writes; accepted on release.
- rst_n pulsed low during RD_HI → o_rsp_valid=0 immediately, o_req_ready=1 after release, next request behaves normally.
